// File: rtl/kmu_pkg.sv
// Shared types for the KMU CTA dispatcher: task payload, launch bundle and FSM states.
// `XLEN defaults to 32 when the build does not provide it.
`ifndef XLEN
`define XLEN 32
`endif

package kmu_pkg;

    localparam int KMU_XLEN = `XLEN;

    typedef struct packed {
        logic [31:0]         num_warps;
        logic [KMU_XLEN-1:0] start_pc;
        logic [KMU_XLEN-1:0] param;
        logic [31:0]         cta_x;
        logic [31:0]         cta_y;
        logic [31:0]         cta_z;
        logic [31:0]         cta_id;
    } kmu_task_t;

    localparam int KMU_TASK_BITS = $bits(kmu_task_t);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_DONE     = 2'd3
    } kmu_disp_state_e;

    typedef struct packed {
        logic [31:0]         grid_x;
        logic [31:0]         grid_y;
        logic [31:0]         grid_z;
        logic [31:0]         num_warps;
        logic [KMU_XLEN-1:0] start_pc;
        logic [KMU_XLEN-1:0] param;
    } kmu_launch_t;

    function automatic logic kmu_grid_empty(input kmu_launch_t l);
        return (l.grid_x == 32'd0) || (l.grid_y == 32'd0) || (l.grid_z == 32'd0);
    endfunction

endpackage

// File: rtl/kmu_cta_iter.sv
// 3-D CTA coordinate walker (x fastest) with a linear id; 'last' flags the final CTA of the grid.
module kmu_cta_iter
    import kmu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        step,
    input  logic [31:0] grid_x,
    input  logic [31:0] grid_y,
    input  logic [31:0] grid_z,
    output logic [31:0] cta_x,
    output logic [31:0] cta_y,
    output logic [31:0] cta_z,
    output logic [31:0] cta_id,
    output logic        last
);

    logic [31:0] x_q, y_q, z_q, id_q;
    logic [31:0] x_d, y_d, z_d, id_d;

    // Next coordinate: clear on launch, otherwise advance x, carrying into y then z.
    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        z_d  = z_q;
        id_d = id_q;
        if (clr) begin
            x_d  = 32'd0;
            y_d  = 32'd0;
            z_d  = 32'd0;
            id_d = 32'd0;
        end else if (step) begin
            id_d = id_q + 32'd1;
            if (x_q == grid_x - 32'd1) begin
                x_d = 32'd0;
                if (y_q == grid_y - 32'd1) begin
                    y_d = 32'd0;
                    z_d = z_q + 32'd1;
                end else begin
                    y_d = y_q + 32'd1;
                end
            end else begin
                x_d = x_q + 32'd1;
            end
        end else begin
            x_d = x_q;
        end
    end

    // Coordinate registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q  <= 32'd0;
            y_q  <= 32'd0;
            z_q  <= 32'd0;
            id_q <= 32'd0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            z_q  <= z_d;
            id_q <= id_d;
        end
    end

    assign cta_x  = x_q;
    assign cta_y  = y_q;
    assign cta_z  = z_q;
    assign cta_id = id_q;
    assign last   = (x_q == grid_x - 32'd1) && (y_q == grid_y - 32'd1) && (z_q == grid_z - 32'd1);

endmodule

// File: rtl/kmu_cta_dispatcher.sv
// KMU front stage: accepts a kernel launch, emits one task per CTA under an in-flight credit limit.
// Optional performance counters are built when KMU_DISPATCH_PERF_EN is defined.
module kmu_cta_dispatcher
    import kmu_pkg::*;
#(
    parameter int MAX_INFLIGHT = 8,
    parameter int XLEN         = `XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            launch_valid,
    output logic            launch_ready,
    input  logic [31:0]     launch_grid_x,
    input  logic [31:0]     launch_grid_y,
    input  logic [31:0]     launch_grid_z,
    input  logic [31:0]     launch_num_warps,
    input  logic [XLEN-1:0] launch_start_pc,
    input  logic [XLEN-1:0] launch_param,
    output logic            task_valid,
    input  logic            task_ready,
    output kmu_task_t       task_data,
    input  logic            core_done,
    output logic            busy,
    output logic            kernel_done
`ifdef KMU_DISPATCH_PERF_EN
    ,
    output logic [63:0]     perf_active_cycles,
    output logic [63:0]     perf_credit_stalls,
    output logic [63:0]     perf_ready_stalls
`endif
);

    localparam int            OW       = $clog2(MAX_INFLIGHT + 1);
    localparam logic [OW-1:0] MAX_CNT  = OW'(MAX_INFLIGHT);
    localparam logic [OW-1:0] CNT_ONE  = OW'(1);
    localparam logic [OW-1:0] CNT_ZERO = OW'(0);

    kmu_disp_state_e state_q, state_d;
    kmu_launch_t     launch_q, launch_d;
    logic [OW-1:0]   outstanding_q, outstanding_d;
    logic            launch_ready_s, task_valid_s, kernel_done_s, fire_s, iter_clr_s, iter_last_s;
    logic [31:0]     cta_x_s, cta_y_s, cta_z_s, cta_id_s;

    // FSM next state, launch capture and credit accounting.
    always_comb begin
        state_d        = state_q;
        launch_d       = launch_q;
        launch_ready_s = 1'b0;
        task_valid_s   = 1'b0;
        kernel_done_s  = 1'b0;
        iter_clr_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                launch_ready_s = 1'b1;
                if (launch_valid) begin
                    launch_d   = '{grid_x: launch_grid_x, grid_y: launch_grid_y,
                                   grid_z: launch_grid_z, num_warps: launch_num_warps,
                                   start_pc: launch_start_pc, param: launch_param};
                    iter_clr_s = 1'b1;
                    state_d    = kmu_grid_empty(launch_d) ? ST_DONE : ST_DISPATCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DISPATCH: begin
                // Credit uses the registered count only; a same-cycle core_done does not help.
                task_valid_s = (outstanding_q < MAX_CNT);
                if (task_valid_s && task_ready && iter_last_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_DISPATCH;
                end
            end
            ST_DRAIN: begin
                if (outstanding_q == CNT_ZERO) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                kernel_done_s = 1'b1;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        fire_s = task_valid_s & task_ready;
        if (fire_s && !core_done) begin
            outstanding_d = outstanding_q + CNT_ONE;
        end else if (!fire_s && core_done && (outstanding_q != CNT_ZERO)) begin
            outstanding_d = outstanding_q - CNT_ONE;
        end else begin
            outstanding_d = outstanding_q;
        end
    end

    // State, launch and credit registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            launch_q      <= '0;
            outstanding_q <= CNT_ZERO;
        end else begin
            state_q       <= state_d;
            launch_q      <= launch_d;
            outstanding_q <= outstanding_d;
        end
    end

    kmu_cta_iter u_iter (
        .clk    (clk),
        .reset  (reset),
        .clr    (iter_clr_s),
        .step   (fire_s),
        .grid_x (launch_q.grid_x),
        .grid_y (launch_q.grid_y),
        .grid_z (launch_q.grid_z),
        .cta_x  (cta_x_s),
        .cta_y  (cta_y_s),
        .cta_z  (cta_z_s),
        .cta_id (cta_id_s),
        .last   (iter_last_s)
    );

    assign launch_ready = launch_ready_s;
    assign task_valid   = task_valid_s;
    assign kernel_done  = kernel_done_s;
    assign busy         = (state_q != ST_IDLE);
    assign task_data    = '{num_warps: launch_q.num_warps, start_pc: launch_q.start_pc,
                            param: launch_q.param, cta_x: cta_x_s, cta_y: cta_y_s,
                            cta_z: cta_z_s, cta_id: cta_id_s};

`ifdef KMU_DISPATCH_PERF_EN
    logic [63:0] perf_active_q, perf_active_d;
    logic [63:0] perf_credit_q, perf_credit_d;
    logic [63:0] perf_ready_q, perf_ready_d;

    // Free-running stall/activity counters, wrapping at 2^64.
    always_comb begin
        perf_active_d = perf_active_q + (busy ? 64'd1 : 64'd0);
        perf_credit_d = perf_credit_q + (((state_q == ST_DISPATCH) && !task_valid_s) ? 64'd1 : 64'd0);
        perf_ready_d  = perf_ready_q + ((task_valid_s && !task_ready) ? 64'd1 : 64'd0);
    end

    // Performance counter registers, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_active_q <= 64'd0;
            perf_credit_q <= 64'd0;
            perf_ready_q  <= 64'd0;
        end else begin
            perf_active_q <= perf_active_d;
            perf_credit_q <= perf_credit_d;
            perf_ready_q  <= perf_ready_d;
        end
    end

    assign perf_active_cycles = perf_active_q;
    assign perf_credit_stalls = perf_credit_q;
    assign perf_ready_stalls  = perf_ready_q;
`endif

endmodule
